// File: rtl/lz77_decoder.sv
// LZ77 triplet decoder: expands (pos, len, literal) into len copied characters plus the literal,
// one character per cycle. Optional end-of-stream detection via macro LZ77_DECODER_END_DETECT_EN.
module lz77_decoder #(
  parameter int SB_DEPTH = 9,
  parameter int MAX_LEN  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [3:0] code_pos,
  input  logic [3:0] code_len,
  input  logic [7:0] chardata,
  output logic       busy,
  output logic       valid,
  output logic [7:0] char_nxt,
  output logic       finish
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COPY = 2'd1;
  localparam logic [1:0] LIT  = 2'd2;

  localparam logic [3:0] LEN_CAP = 4'(MAX_LEN);

  logic [1:0] state;
  logic [3:0] pos_q;
  logic [3:0] cnt_q;
  logic [7:0] lit_q;
  logic [7:0] sb [SB_DEPTH];

  logic [7:0] sb_rd;
  logic [7:0] shift_in;
  logic       shift_en;
  logic       is_end;
  logic [3:0] len_sat;

  assign len_sat = (code_len > LEN_CAP) ? LEN_CAP : code_len;

  // Out-of-range offsets fall through the mux and read as zero.
  always_comb begin
    sb_rd = 8'h00;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (int'(pos_q) == i) sb_rd = sb[i];
    end
  end

  assign shift_en = (state == COPY) || (state == LIT);
  assign shift_in = (state == COPY) ? sb_rd : lit_q;

`ifdef LZ77_DECODER_END_DETECT_EN
  assign is_end = (state == LIT) && (lit_q == 8'h24);
`else
  assign is_end = 1'b0;
`endif

  // NOTE: the search buffer is reset explicitly because unwritten entries must read as zero;
  // a plain memory without reset would return garbage for early back-references.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= 8'h00;
    end else if (is_end) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= 8'h00;
    end else if (shift_en) begin
      for (int i = SB_DEPTH - 1; i > 0; i--) sb[i] <= sb[i-1];
      sb[0] <= shift_in;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pos_q    <= 4'd0;
      cnt_q    <= 4'd0;
      lit_q    <= 8'h00;
      busy     <= 1'b0;
      valid    <= 1'b0;
      char_nxt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (code_valid) begin
            pos_q <= code_pos;
            cnt_q <= len_sat;
            lit_q <= chardata;
            busy  <= 1'b1;
            state <= (len_sat != 4'd0) ? COPY : LIT;
          end
        end
        COPY: begin
          char_nxt <= sb_rd;
          valid    <= 1'b1;
          cnt_q    <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state <= LIT;
        end
        LIT: begin
          char_nxt <= lit_q;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LZ77_DECODER_END_DETECT_EN
  logic finish_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) finish_q <= 1'b0;
    else        finish_q <= is_end;
  end
  assign finish = finish_q;
`else
  assign finish = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder: a reference search-buffer model fills a scoreboard queue
// as triplets are driven; a monitor pops and compares each valid character.
module tb_lz77_decoder;

  localparam int SB_DEPTH = 9;
  localparam int MAX_LEN  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_pos = 4'd0;
  logic [3:0] code_len = 4'd0;
  logic [7:0] chardata = 8'h00;
  logic       busy;
  logic       valid;
  logic [7:0] char_nxt;
  logic       finish;

  lz77_decoder #(.SB_DEPTH(SB_DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .code_valid(code_valid),
    .code_pos  (code_pos),
    .code_len  (code_len),
    .chardata  (chardata),
    .busy      (busy),
    .valid     (valid),
    .char_nxt  (char_nxt),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ch;
    logic       fin;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] msb [SB_DEPTH];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_shift(logic [7:0] c);
    for (int i = SB_DEPTH - 1; i > 0; i--) msb[i] = msb[i-1];
    msb[0] = c;
  endtask

  task automatic model_clear();
    for (int i = 0; i < SB_DEPTH; i++) msb[i] = 8'h00;
  endtask

  task automatic model_push(int pos, int len, logic [7:0] ch);
    int         elen;
    logic [7:0] c;
    elen = (len > MAX_LEN) ? MAX_LEN : len;
    for (int k = 0; k < elen; k++) begin
      c = (pos < SB_DEPTH) ? msb[pos] : 8'h00;
      q.push_back('{c, 1'b0});
      model_shift(c);
    end
`ifdef LZ77_DECODER_END_DETECT_EN
    if (ch == 8'h24) begin
      q.push_back('{ch, 1'b1});
      model_clear();
    end else begin
      q.push_back('{ch, 1'b0});
      model_shift(ch);
    end
`else
    q.push_back('{ch, 1'b0});
    model_shift(ch);
`endif
  endtask

  // Monitor: every valid cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("char_nxt", 32'(char_nxt), 32'(mon_e.ch));
          check("finish_on_valid", 32'(finish), 32'(mon_e.fin));
        end
      end else begin
        check("finish_idle", 32'(finish), 32'd0);
      end
    end
  end

  // Drives one triplet from a negedge with busy low, then checks the busy/valid timeline.
  task automatic send(int pos, int len, logic [7:0] ch, bit glitch);
    int elen;
    elen = (len > MAX_LEN) ? MAX_LEN : len;
    check("busy_before_send", 32'(busy), 32'd0);
    model_push(pos, len, ch);
    code_valid = 1'b1;
    code_pos   = pos[3:0];
    code_len   = len[3:0];
    chardata   = ch;
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("valid_after_accept", 32'(valid), 32'd0);
    for (int k = 1; k <= elen + 1; k++) begin
      if (glitch && k == 2) begin
        code_valid = 1'b1;
        code_pos   = 4'd3;
        code_len   = 4'd2;
        chardata   = 8'h7e;
      end
      if (glitch && k == 3) code_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("valid_run", 32'(valid), 32'd1);
      check("busy_run", 32'(busy), (k <= elen) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("valid_low_after_drain", 32'(valid), 32'd0);
  endtask

  initial begin
    model_clear();

    // Reset state
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_char", 32'(char_nxt), 32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single literal straight out of reset, then overlapping run with an ignored code_valid pulse
    send(0, 0, 8'h41, 1'b0);
    send(0, 5, 8'h42, 1'b1);
    drain();

    // Literals A,B,C then a copy replaying them followed by D
    send(0, 0, 8'h41, 1'b0);
    send(0, 0, 8'h42, 1'b0);
    send(0, 0, 8'h43, 1'b0);
    send(2, 3, 8'h44, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("char_hold", 32'(char_nxt), 32'h44);

    // Reset in the middle of a copy run
    q.push_back('{msb[1], 1'b0});
    q.push_back('{msb[0], 1'b0});
    code_valid = 1'b1;
    code_pos   = 4'd1;
    code_len   = 4'd4;
    chardata   = 8'h51;
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_char", 32'(char_nxt), 32'd0);
    check("midreset_finish", 32'(finish), 32'd0);
    check("midreset_popped", 32'(q.size()), 32'd0);
    q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_valid_after_reset", 32'(valid), 32'd0);
    end

    // Saturated length with out-of-range position
    send(12, 15, 8'h5a, 1'b0);
    drain();

    // End marker handling, then a copy that observes whether the buffer was cleared
    send(0, 0, 8'h24, 1'b0);
    send(0, 1, 8'h78, 1'b0);
    drain();

    // Overlap with period pos+1
    send(1, 6, 8'h6b, 1'b0);
    drain();
    check("char_hold_end", 32'(char_nxt), 32'h6b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
